// File: rtl/mips_multicycle_control_if.sv
// ----------------------------------------------------------------------------
// mips_multicycle_control_if
//
// Groups the signals exchanged between the multi-cycle control sequencer and
// the shared-memory MIPS datapath.
//   opcode      : instruction[31:26] from the instruction register
//   mem_ready   : memory completes the current access this cycle
//   pc_write .. alu_src_a : single-bit datapath controls
//   alu_src_b   : 00 rt, 01 constant 4, 10 sign-ext imm, 11 shifted imm
//   alu_op      : 00 add, 01 sub, 10 funct, 11 addi
//   pc_source   : 00 ALU, 01 ALUOut, 10 jump target
//   instr_done  : pulse in the final cycle of each instruction
//   trap        : pulse in the TRAP cycle; trap_cause 0 illegal, 1 timeout
//   state       : current sequencer state, for debug
//
// master : the controller (consumes opcode/mem_ready, drives the controls)
// slave  : the datapath side
// ----------------------------------------------------------------------------
interface mips_multicycle_control_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       trap;
    logic       trap_cause;
    logic [3:0] state;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write,
               ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
               alu_src_b, alu_op, pc_source, instr_done, trap, trap_cause,
               state
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write,
               ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
               alu_src_b, alu_op, pc_source, instr_done, trap, trap_cause,
               state
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// ----------------------------------------------------------------------------
// mips_multicycle_control
//
// Moore control sequencer for the multi-cycle MIPS datapath. Steps each
// instruction through fetch / decode / execute / memory / writeback, waits
// on memory wait states with a bounded timeout, and traps illegal opcodes.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mips_multicycle_control_if.master (opcode, mem_ready in;
//           datapath controls, instr_done, trap, trap_cause, state out)
// Parameters:
//   WAIT_LIMIT : max not-ready cycles per access (0 = no timeout)
//   CNT_W      : wait counter width, 2**CNT_W > WAIT_LIMIT
// Optional feature macro:
//   CTRL_BNE_EN : decode opcode 000101 (bne) to BRANCH with branch_ne = 1
// ----------------------------------------------------------------------------
module mips_multicycle_control #(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    mips_multicycle_control_if.master  bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC     = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(WAIT_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cause_q, cause_d;
    // Outputs are held at zero for the first cycle after reset release.
    logic               active_q;
    logic               timeout;
    logic               wait_state;
`ifdef CTRL_BNE_EN
    logic               bne_q, bne_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            cnt_q    <= '0;
            cause_q  <= 1'b0;
            active_q <= 1'b0;
`ifdef CTRL_BNE_EN
            bne_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cause_q  <= cause_d;
            active_q <= 1'b1;
`ifdef CTRL_BNE_EN
            bne_q    <= bne_d;
`endif
        end
    end

    assign wait_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                        (state_q == S_MEM_WR);
    // A ready memory in the limit cycle still completes the access.
    assign timeout = (WAIT_LIMIT != 0) && (cnt_q == LIMIT) && !bus.mem_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
`ifdef CTRL_BNE_EN
        bne_d   = bne_q;
`endif
        case (state_q)
            S_FETCH: begin
                if (bus.mem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_TRAP;
                    cause_d = 1'b1;
                end
            end
            S_DECODE: begin
                case (bus.opcode)
                    6'b000000:            state_d = S_EXEC;
                    6'b100011, 6'b101011: state_d = S_MEM_ADDR;
                    6'b000100: begin
                        state_d = S_BRANCH;
`ifdef CTRL_BNE_EN
                        bne_d   = 1'b0;
`endif
                    end
`ifdef CTRL_BNE_EN
                    6'b000101: begin
                        state_d = S_BRANCH;
                        bne_d   = 1'b1;
                    end
`endif
                    6'b000010:            state_d = S_JUMP;
                    6'b001000:            state_d = S_ADDI_EX;
                    default: begin
                        state_d = S_TRAP;
                        cause_d = 1'b0;
                    end
                endcase
            end
            // Only lw and sw reach MEM_ADDR; opcode bit 3 separates them.
            S_MEM_ADDR: state_d = bus.opcode[3] ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD, S_MEM_WR: begin
                if (bus.mem_ready) begin
                    state_d = (state_q == S_MEM_RD) ? S_MEM_WB : S_FETCH;
                end else if (timeout) begin
                    state_d = S_TRAP;
                    cause_d = 1'b1;
                end
            end
            S_EXEC:    state_d = S_R_WB;
            S_ADDI_EX: state_d = S_ADDI_WB;
            default:   state_d = S_FETCH;
        endcase

        // The sequencer does not advance until the masking cycle is over.
        if (!active_q) begin
            state_d = state_q;
            cause_d = cause_q;
        end

        // Counter restarts whenever a state is entered and counts stalls.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (active_q && wait_state && !bus.mem_ready) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.branch_ne     = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.alu_op        = 2'b00;
        bus.pc_source     = 2'b00;
        bus.instr_done    = 1'b0;
        bus.trap          = 1'b0;
        bus.trap_cause    = 1'b0;
        bus.state         = 4'd0;
        if (active_q) begin
            bus.state = state_q;
            case (state_q)
                S_FETCH: begin
                    bus.mem_read  = 1'b1;
                    bus.alu_src_b = 2'b01;
                    bus.ir_write  = bus.mem_ready;
                    bus.pc_write  = bus.mem_ready;
                end
                S_DECODE: bus.alu_src_b = 2'b11;
                S_MEM_ADDR: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'b10;
                end
                S_MEM_RD: begin
                    bus.mem_read = 1'b1;
                    bus.i_or_d   = 1'b1;
                end
                S_MEM_WB: begin
                    bus.mem_to_reg = 1'b1;
                    bus.reg_write  = 1'b1;
                    bus.instr_done = 1'b1;
                end
                S_MEM_WR: begin
                    bus.mem_write  = 1'b1;
                    bus.i_or_d     = 1'b1;
                    bus.instr_done = bus.mem_ready;
                end
                S_EXEC: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_op    = 2'b10;
                end
                S_R_WB: begin
                    bus.reg_dst    = 1'b1;
                    bus.reg_write  = 1'b1;
                    bus.instr_done = 1'b1;
                end
                S_BRANCH: begin
                    bus.alu_src_a     = 1'b1;
                    bus.alu_op        = 2'b01;
                    bus.pc_write_cond = 1'b1;
                    bus.pc_source     = 2'b01;
                    bus.instr_done    = 1'b1;
`ifdef CTRL_BNE_EN
                    bus.branch_ne     = bne_q;
`endif
                end
                S_JUMP: begin
                    bus.pc_write   = 1'b1;
                    bus.pc_source  = 2'b10;
                    bus.instr_done = 1'b1;
                end
                S_ADDI_EX: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'b10;
                    bus.alu_op    = 2'b11;
                end
                S_ADDI_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.instr_done = 1'b1;
                end
                S_TRAP: begin
                    bus.trap       = 1'b1;
                    bus.trap_cause = cause_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// ----------------------------------------------------------------------------
// tb_mips_multicycle_control
//
// Two sequencers: u_main with the default wait limit (15) and u_lim with a
// wait limit of 2. Only one is out of reset at a time. Each instruction is
// described as a list of steps (state code, mem_ready) generated from the
// instruction's class and its wait-state pattern; the expected outputs of
// each step come from the per-state control table.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mips_multicycle_control;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       trap;
        logic       trap_cause;
        logic [3:0] state;
    } ctrl_t;

    logic       clk = 1'b0;
    logic       rst_m = 1'b0;
    logic       rst_l = 1'b0;
    logic [5:0] op_v = 6'd0;
    logic       ready_v = 1'b1;
    int         tgt = 0;
    int         n_cyc = 0;
    int         checks = 0;
    int         errors = 0;
    bit         chk_on = 1'b0;
    ctrl_t      exp_m = '0;
    ctrl_t      exp_l = '0;
    ctrl_t      act_m, act_l;
    bit         seen_ir_l, seen_wr_m;

    always #5 clk = ~clk;

    mips_multicycle_control_if ifm ();
    mips_multicycle_control_if ifl ();

    assign ifm.opcode = op_v;
    assign ifm.mem_ready = ready_v;
    assign ifl.opcode = op_v;
    assign ifl.mem_ready = ready_v;

    mips_multicycle_control #(.WAIT_LIMIT(15), .CNT_W(4)) u_main (
        .clk(clk), .rst_n(rst_m), .bus(ifm.master));
    mips_multicycle_control #(.WAIT_LIMIT(2), .CNT_W(2)) u_lim (
        .clk(clk), .rst_n(rst_l), .bus(ifl.master));

    assign act_m = {ifm.pc_write, ifm.pc_write_cond, ifm.branch_ne, ifm.i_or_d,
                    ifm.mem_read, ifm.mem_write, ifm.ir_write, ifm.mem_to_reg,
                    ifm.reg_dst, ifm.reg_write, ifm.alu_src_a, ifm.alu_src_b,
                    ifm.alu_op, ifm.pc_source, ifm.instr_done, ifm.trap,
                    ifm.trap_cause, ifm.state};
    assign act_l = {ifl.pc_write, ifl.pc_write_cond, ifl.branch_ne, ifl.i_or_d,
                    ifl.mem_read, ifl.mem_write, ifl.ir_write, ifl.mem_to_reg,
                    ifl.reg_dst, ifl.reg_write, ifl.alu_src_a, ifl.alu_src_b,
                    ifl.alu_op, ifl.pc_source, ifl.instr_done, ifl.trap,
                    ifl.trap_cause, ifl.state};

    // Control table: what each state drives (code < 0 means all zero).
    function automatic ctrl_t exp_of(input int code, input bit rdy,
                                     input bit cause, input bit bne);
        ctrl_t c = '0;
        if (code < 0) return c;
        c.state = 4'(code);
        case (code)
            0:  begin c.mem_read = 1; c.alu_src_b = 2'b01;
                      c.ir_write = rdy; c.pc_write = rdy; end
            1:  c.alu_src_b = 2'b11;
            2:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            3:  begin c.mem_read = 1; c.i_or_d = 1; end
            4:  begin c.mem_to_reg = 1; c.reg_write = 1; c.instr_done = 1; end
            5:  begin c.mem_write = 1; c.i_or_d = 1; c.instr_done = rdy; end
            6:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
            7:  begin c.reg_dst = 1; c.reg_write = 1; c.instr_done = 1; end
            8:  begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1;
                      c.pc_source = 2'b01; c.instr_done = 1; c.branch_ne = bne; end
            9:  begin c.pc_write = 1; c.pc_source = 2'b10; c.instr_done = 1; end
            10: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_op = 2'b11; end
            11: begin c.reg_write = 1; c.instr_done = 1; end
            12: begin c.trap = 1; c.trap_cause = cause; end
            default: ;
        endcase
        return c;
    endfunction

    // Per-cycle compare of both sequencers against the expectation.
    always @(negedge clk) begin
        if (chk_on) begin
            checks++;
            if (act_m !== exp_m) begin
                errors++;
                $display("FAIL main_cycle t=%0t act=%h exp=%h", $time, act_m, exp_m);
            end
            checks++;
            if (act_l !== exp_l) begin
                errors++;
                $display("FAIL lim_cycle t=%0t act=%h exp=%h", $time, act_l, exp_l);
            end
            if (ifl.ir_write) seen_ir_l = 1'b1;
            if (ifm.reg_write || ifm.mem_write) seen_wr_m = 1'b1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    // One clock cycle of the active sequencer in the given state.
    task automatic do_cycle(input int code, input bit rdy, input bit cause,
                            input bit bne);
        ready_v = rdy;
        if (tgt == 0) begin
            exp_m = exp_of(code, rdy, cause, bne); exp_l = '0;
        end else begin
            exp_l = exp_of(code, rdy, cause, bne); exp_m = '0;
        end
        n_cyc++;
        @(posedge clk);
        #1;
    endtask

    // Memory access: wn stall cycles then completion, or a timeout.
    task automatic access(input int code, input int wn, input int lim,
                          output bit to);
        to = 1'b0;
        for (int k = 0; k < wn; k++) begin
            do_cycle(code, 1'b0, 1'b0, 1'b0);
            if (lim != 0 && k == lim) begin
                to = 1'b1;
                return;
            end
        end
        do_cycle(code, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic run(input logic [5:0] op, input int wf, input int wm,
                       output int ncyc);
        int  lim = (tgt == 0) ? 15 : 2;
        int  start = n_cyc;
        bit  to;
        op_v = op;
        access(0, wf, lim, to);
        if (to) begin
            do_cycle(12, 1'b1, 1'b1, 1'b0);
        end else begin
            do_cycle(1, 1'b1, 1'b0, 1'b0);
            case (op)
                6'b000000: begin do_cycle(6, 1, 0, 0); do_cycle(7, 1, 0, 0); end
                6'b100011: begin
                    do_cycle(2, 1, 0, 0);
                    access(3, wm, lim, to);
                    if (to) do_cycle(12, 1, 1, 0); else do_cycle(4, 1, 0, 0);
                end
                6'b101011: begin
                    do_cycle(2, 1, 0, 0);
                    access(5, wm, lim, to);
                    if (to) do_cycle(12, 1, 1, 0);
                end
                6'b000100: do_cycle(8, 1, 0, 0);
                6'b000010: do_cycle(9, 1, 0, 0);
                6'b001000: begin do_cycle(10, 1, 0, 0); do_cycle(11, 1, 0, 0); end
`ifdef CTRL_BNE_EN
                6'b000101: do_cycle(8, 1, 0, 1);
`endif
                default:   do_cycle(12, 1, 0, 0);
            endcase
        end
        ncyc = n_cyc - start;
        $display("dut=%0d op=%b wf=%0d wm=%0d cycles=%0d", tgt, op, wf, wm, ncyc);
    endtask

    initial begin
        int n;
        @(posedge clk); #1;
        chk_on = 1'b1;
        // Reset held
        do_cycle(-1, 1, 0, 0);
        do_cycle(-1, 1, 0, 0);
        chk("reset_state", int'(ifm.state), 0);
        chk("reset_mem_read", int'(ifm.mem_read), 0);

        // Release: one masked cycle, then lw with no wait states
        rst_m = 1'b1;
        do_cycle(-1, 1, 0, 0);
        run(6'b100011, 0, 0, n); chk("lw_latency", n, 5);
        run(6'b101011, 0, 3, n); chk("sw_wait3_latency", n, 7);
        run(6'b000100, 0, 0, n); chk("beq_latency", n, 3);
        run(6'b000010, 0, 0, n); chk("j_latency", n, 3);
        run(6'b001000, 0, 0, n); chk("addi_latency", n, 4);
        run(6'b000000, 0, 0, n); chk("rtype_latency", n, 4);
        seen_wr_m = 1'b0;
        run(6'b111111, 0, 0, n); chk("illegal_latency", n, 3);
        chk("illegal_no_write", int'(seen_wr_m), 0);
        run(6'b000101, 0, 0, n); chk("bne_latency", n, 3);
        run(6'b100011, 2, 1, n); chk("lw_waits_latency", n, 8);
        // Ready in the limit cycle completes; one more stall times out
        run(6'b000010, 15, 0, n); chk("limit_ready_wins", n, 18);
        run(6'b000010, 16, 0, n); chk("fetch_timeout15", n, 17);

        // Reset during MEM_WR: write strobe drops immediately
        op_v = 6'b101011;
        do_cycle(0, 1, 0, 0); do_cycle(1, 1, 0, 0); do_cycle(2, 1, 0, 0);
        do_cycle(5, 0, 0, 0);
        chk("mem_wr_before_rst", int'(ifm.mem_write), 1);
        rst_m = 1'b0;
        #1;
        chk("mem_wr_after_rst", int'(ifm.mem_write), 0);
        do_cycle(-1, 1, 0, 0);
        rst_m = 1'b1;
        do_cycle(-1, 1, 0, 0);
        run(6'b000000, 0, 0, n); chk("recover_rtype", n, 4);

        // Limited-wait sequencer
        rst_m = 1'b0;
        tgt = 1;
        do_cycle(-1, 1, 0, 0);
        rst_l = 1'b1;
        do_cycle(-1, 1, 0, 0);
        seen_ir_l = 1'b0;
        run(6'b100011, 5, 0, n); chk("lim_fetch_timeout", n, 4);
        chk("lim_no_ir_write", int'(seen_ir_l), 0);
        run(6'b101011, 0, 2, n); chk("lim_sw_ready_at_limit", n, 6);
        run(6'b100011, 0, 3, n); chk("lim_rd_timeout", n, 7);
        run(6'b001000, 0, 0, n); chk("lim_addi_after_trap", n, 4);

        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout_watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Multi-cycle control sequencer for the MIPS datapath. It replaces the single-cycle opcode decoder with a Moore FSM that steps each instruction through fetch, decode, execute, memory and writeback. It adds memory wait-state handshaking, a bounded wait timeout and an illegal-opcode trap. It sits between the instruction register opcode field and the shared-memory multi-cycle datapath.

## Interface
- `WAIT_LIMIT`, 15: maximum memory not-ready cycles tolerated per access; 0 disables the timeout.
- `CNT_W`, 4: width of the wait counter; must satisfy 2^CNT_W > WAIT_LIMIT.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 6: instruction[31:26], taken from the instruction register.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pc_write`, `pc_write_cond`, `branch_ne`, `i_or_d`, `mem_read`, `mem_write`, `ir_write`, `mem_to_reg`, `reg_dst`, `reg_write`, `alu_src_a` out 1 each: datapath controls.
- `alu_src_b` out 2: 00 = rt, 01 = 4, 10 = sign-extended immediate, 11 = shifted immediate.
- `alu_op` out 2: 00 = add, 01 = sub, 10 = funct, 11 = addi.
- `pc_source` out 2: 00 = ALU, 01 = ALUOut, 10 = jump target.
- `instr_done` out 1: pulse in the final cycle of each instruction.
- `trap` out 1: pulse in the TRAP cycle.
- `trap_cause` out 1: 0 = illegal opcode, 1 = memory timeout; valid while `trap` = 1.
- `state` out 4: current state encoding, for debug.

## Operation
- States and encodings:
  - FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_RD = 3, MEM_WB = 4, MEM_WR = 5.
  - EXEC = 6, R_WB = 7, BRANCH = 8, JUMP = 9, ADDI_EX = 10, ADDI_WB = 11, TRAP = 12.
  - Codes 13–15 go to FETCH.
- Every control not listed for a state is 0.
- FETCH:
  - Asserts `mem_read`, `alu_src_b` = 01.
  - `ir_write` = `pc_write` = `mem_ready`.
  - Advances to DECODE on `mem_ready`.
- DECODE: `alu_src_b` = 11. Next state by opcode:
  - 000000 → EXEC; 100011 or 101011 → MEM_ADDR.
  - 000100 → BRANCH; 000010 → JUMP; 001000 → ADDI_EX.
  - Any other opcode → TRAP with cause 0.
- MEM_ADDR: `alu_src_a` = 1, `alu_src_b` = 10. Goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: `mem_read`, `i_or_d`; waits for `mem_ready`, then MEM_WB.
- MEM_WB: `mem_to_reg`, `reg_write`, `instr_done`; then FETCH.
- MEM_WR:
  - `mem_write`, `i_or_d`; `instr_done` = `mem_ready`.
  - Waits for `mem_ready`, then FETCH.
- EXEC: `alu_src_a` = 1, `alu_op` = 10; then R_WB.
- R_WB: `reg_dst`, `reg_write`, `instr_done`; then FETCH.
- BRANCH: `alu_src_a` = 1, `alu_op` = 01, `pc_write_cond`, `pc_source` = 01, `instr_done`; then FETCH.
- JUMP: `pc_write`, `pc_source` = 10, `instr_done`; then FETCH.
- ADDI_EX: `alu_src_a` = 1, `alu_src_b` = 10, `alu_op` = 11; then ADDI_WB.
- ADDI_WB: `reg_write`, `instr_done`; then FETCH.
- TRAP: `trap` = 1, `trap_cause` from its register; then FETCH.
- Wait counter, active in FETCH, MEM_RD and MEM_WR:
  - Cleared on entry to each of these states.
  - Increments each cycle that `mem_ready` = 0.
  - If `WAIT_LIMIT` ≠ 0, the counter equals `WAIT_LIMIT` and `mem_ready` = 0, the FSM goes to TRAP with cause 1. The access is abandoned; no `ir_write` or `pc_write`.
  - `mem_ready` = 1 in the limit cycle wins; the access completes normally.
- `trap_cause` register is written only on entry to TRAP.

## Timing
- Reset, while `rst_n` = 0:
  - State = FETCH, counter = 0, `trap_cause` = 0, `active` flop = 0.
  - All outputs are 0, including `state`.
- After reset release:
  - The first edge sets `active`.
  - Outputs stay masked to 0 until `active` = 1; FETCH behaviour starts on the second cycle.
- Asserting `rst_n` mid-instruction returns the FSM to FETCH at once. No write strobe may remain high after the assertion.
- Outputs are a Moore decode of the state register. The only exceptions are `ir_write`, `pc_write` in FETCH and `instr_done` in MEM_WR, which are additionally gated by `mem_ready`.
- Latency with zero wait states:
  - lw = 5 cycles; sw, R-type and addi = 4 cycles; beq and j = 3 cycles.
  - An illegal opcode costs 3 cycles.
- Each not-ready cycle adds exactly 1 cycle of latency.

## Configuration
- `CTRL_BNE_EN` defined:
  - Opcode 000101 decodes to BRANCH with `branch_ne` = 1 held for that BRANCH cycle.
  - Same outputs and latency as beq.
- `CTRL_BNE_EN` undefined:
  - 000101 is illegal and goes to TRAP with cause 0.
  - `branch_ne` is tied to 0.

## Test plan
- Reset release, `mem_ready` tied to 1, lw (100011): all outputs 0 for 1 cycle, then state sequence 0, 1, 2, 3, 4, 0. `instr_done` is high only in state 4; `reg_write` = `mem_to_reg` = 1 there.
- sw with `mem_ready` low for 3 cycles in MEM_WR: `mem_write` and `i_or_d` are high for 4 cycles, and the instruction takes 7 cycles total.
- `WAIT_LIMIT` = 2, `mem_ready` held 0 in FETCH: after 3 not-ready cycles, `trap` = 1 with `trap_cause` = 1, then FETCH. `ir_write` never rises.
- Opcode 111111: FETCH, DECODE, then TRAP with `trap` = 1 and `trap_cause` = 0. No `reg_write` or `mem_write` is asserted at any point.
- Sequence beq, j, addi, R-type: the BRANCH, JUMP, ADDI_EX/ADDI_WB and EXEC/R_WB encodings appear with `alu_op` 01, —, 11 and 10 respectively, and `pc_source` 01 and 10 for beq and j.
- Opcode 000101: with `CTRL_BNE_EN` defined, reaches BRANCH with `branch_ne` = 1; without it, `trap_cause` = 0. Separately, drop `rst_n` mid-MEM_WR: `mem_write` falls in the same cycle.
